// File: rtl/display_scheduler.sv
// -----------------------------------------------------------------------------
// display_scheduler
//
// Time-multiplexes one shared 4-bit code encoder and one 7-segment decoder path
// across DIGITS display positions. A small per-digit register file holds a code
// value and a lit/blanked enable for each slot. The host writes it through a
// valid/ready load port.
//
// Each slot goes through three phases:
//   BLANK : all digits off for BLANK_CYCLES cycles (anti-ghosting)
//   DRIVE : one cycle presenting the slot value and enable to the encoder
//   SHOW  : SCAN_DIV cycles with the captured code held and the slot's digit lit
//
// Ports
//   Clock        in   system clock, rising edge
//   Reset        in   asynchronous, active-high reset
//   Load_Valid   in   host write request
//   Load_Ready   out  write can be accepted this cycle (low in DRIVE and reset)
//   Load_Index   in   target slot; indices >= DIGITS are accepted and dropped
//   Load_Value   in   4-bit code value for the slot
//   Load_Enable  in   slot lit (1) / blanked (0)
//   Enc_Input    out  value to the shared encoder
//   Enc_Ready    out  encoder enable (encoder forces 0 when low)
//   Enc_Output   in   encoder result, combinational return path
//   Seg_Code     out  code captured on the edge leaving DRIVE
//   Digit_Select out  one-hot, active-high digit enable
//   Frame_Done   out  one-cycle pulse in the first BLANK cycle after a wrap
//   Brightness   in   (only with SCHED_BRIGHTNESS_EN) 3-bit duty setting
//
// Build option
//   SCHED_BRIGHTNESS_EN : adds the Brightness input. The digit is lit only for
//   the first max(1, ((Brightness+1)*SCAN_DIV)>>3) cycles of SHOW. Brightness
//   is sampled at SHOW entry. SHOW length, and so frame timing, is unchanged.
//
// All outputs are registered. Each output flop is loaded from the value the
// output must take in the *next* state, so outputs line up with the state
// register rather than lagging it by a cycle.
// -----------------------------------------------------------------------------
module display_scheduler #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 2,
  localparam int IDX_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Load_Valid,
  output logic              Load_Ready,
  input  logic [IDX_W-1:0]  Load_Index,
  input  logic [3:0]        Load_Value,
  input  logic              Load_Enable,
  output logic [3:0]        Enc_Input,
  output logic              Enc_Ready,
  input  logic [3:0]        Enc_Output,
  output logic [3:0]        Seg_Code,
  output logic [DIGITS-1:0] Digit_Select,
  output logic              Frame_Done
`ifdef SCHED_BRIGHTNESS_EN
  ,
  input  logic [2:0]        Brightness
`endif
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] PTR_LAST   = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_DRIVE = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  // Sequencer
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;

  // Slot register file
  logic [3:0]         slot_val_q [DIGITS];
  logic [3:0]         slot_val_d [DIGITS];
  logic [DIGITS-1:0]  slot_en_q, slot_en_d;

  // Registered outputs
  logic               load_ready_q, load_ready_d;
  logic [3:0]         enc_input_q, enc_input_d;
  logic               enc_ready_q, enc_ready_d;
  logic [3:0]         seg_code_q, seg_code_d;
  logic [DIGITS-1:0]  digit_sel_q, digit_sel_d;
  logic               frame_done_q, frame_done_d;

  // Write decode
  logic               xfer;
  logic [DIGITS-1:0]  wr_hit;
  logic               fwd;
  logic               lit_ok;

  // A transfer happens whenever the host is valid and we advertised ready.
  // Indices outside 0..DIGITS-1 match no slot, so the write is simply dropped
  // while the handshake still completes.
  assign xfer = Load_Valid & load_ready_q;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_wr_decode
    assign wr_hit[gi] = xfer && (Load_Index == IDX_W'(gi));
  end

  // A write landing on the same edge that enters DRIVE for that slot is
  // forwarded, so the host never loses a frame to that race.
  assign fwd = wr_hit[ptr_q];

  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      slot_val_d[i] = slot_val_q[i];
    end
    slot_en_d = slot_en_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (wr_hit[i]) begin
        slot_val_d[i] = Load_Value;
        slot_en_d[i]  = Load_Enable;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. The counter restarts from 0 on every state entry.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    ptr_d        = ptr_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end
      end
      ST_DRIVE: begin
        state_d = ST_SHOW;
        cnt_d   = '0;
      end
      ST_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (ptr_q == PTR_LAST) begin
            ptr_d        = '0;
            frame_done_d = 1'b1;
          end else begin
            ptr_d = ptr_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
        ptr_d   = '0;
      end
    endcase
  end

`ifdef SCHED_BRIGHTNESS_EN
  // On-time for the current SHOW. The product fits CNT_W+3 bits because
  // (Brightness+1) <= 8 and SCAN_DIV < 2**CNT_W.
  localparam int PROD_W = CNT_W + 3;

  logic [PROD_W-1:0] on_prod;
  logic [CNT_W-1:0]  on_entry;
  logic [CNT_W-1:0]  on_cycles_q, on_cycles_d;

  assign on_prod = (PROD_W'(Brightness) + PROD_W'(1)) * PROD_W'(SCAN_DIV);

  always_comb begin
    on_entry = CNT_W'(on_prod >> 3);
    if (on_entry == '0) begin
      on_entry = CNT_W'(1);
    end
    // Brightness is sampled only on the edge that enters SHOW.
    on_cycles_d = (state_q == ST_DRIVE) ? on_entry : on_cycles_q;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      on_cycles_q <= '0;
    end else begin
      on_cycles_q <= on_cycles_d;
    end
  end

  // cnt_d is the SHOW cycle index of the cycle the output flop is loading for.
  assign lit_ok = (cnt_d < on_cycles_d);
`else
  assign lit_ok = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Output values for the upcoming cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    load_ready_d = (state_d != ST_DRIVE);
    enc_input_d  = 4'd0;
    enc_ready_d  = 1'b0;
    digit_sel_d  = '0;
    // Enc_Output is the encoder's answer to the DRIVE-cycle inputs.
    seg_code_d   = (state_q == ST_DRIVE) ? Enc_Output : seg_code_q;
    if (state_d == ST_DRIVE) begin
      enc_input_d = fwd ? Load_Value  : slot_val_q[ptr_q];
      enc_ready_d = fwd ? Load_Enable : slot_en_q[ptr_q];
    end
    if ((state_d == ST_SHOW) && lit_ok) begin
      digit_sel_d = DIGITS'(1) << ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      ptr_q        <= '0;
      for (int i = 0; i < DIGITS; i++) begin
        slot_val_q[i] <= 4'd0;
      end
      slot_en_q    <= '0;
      load_ready_q <= 1'b0;
      enc_input_q  <= 4'd0;
      enc_ready_q  <= 1'b0;
      seg_code_q   <= 4'd0;
      digit_sel_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      for (int i = 0; i < DIGITS; i++) begin
        slot_val_q[i] <= slot_val_d[i];
      end
      slot_en_q    <= slot_en_d;
      load_ready_q <= load_ready_d;
      enc_input_q  <= enc_input_d;
      enc_ready_q  <= enc_ready_d;
      seg_code_q   <= seg_code_d;
      digit_sel_q  <= digit_sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign Load_Ready   = load_ready_q;
  assign Enc_Input    = enc_input_q;
  assign Enc_Ready    = enc_ready_q;
  assign Seg_Code     = seg_code_q;
  assign Digit_Select = digit_sel_q;
  assign Frame_Done   = frame_done_q;

endmodule

// File: tb/tb_display_scheduler.sv
// -----------------------------------------------------------------------------
// tb_display_scheduler
//
// Two instances: the main one (DIGITS=4, BLANK_CYCLES=2, SCAN_DIV=4, or 8 when
// SCHED_BRIGHTNESS_EN is defined) and a DIGITS=3 one that only ever receives
// writes to index 3, which must be accepted and dropped.
//
// The reference model works from the cycle number since reset release: slot
// and phase follow from plain division by the slot period. A slot register
// array is updated on each accepted write. Every cycle, on the falling edge,
// all outputs of both instances are compared with the model. A few literal
// expectations pin the model itself.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_display_scheduler;

  localparam int DIGITS = 4;
  localparam int BLANK  = 2;
`ifdef SCHED_BRIGHTNESS_EN
  localparam int SCAN      = 8;
  localparam int FRAME_LIT = 44;
  localparam int LIT0_LIT  = 16;
  localparam int SHOW_LIT  = 8;
`else
  localparam int SCAN      = 4;
  localparam int FRAME_LIT = 28;
  localparam int LIT0_LIT  = 8;
  localparam int SHOW_LIT  = 4;
`endif
  localparam int PER        = BLANK + 1 + SCAN;
  localparam int FRAME      = DIGITS * PER;
  localparam int PER3       = 7;
  localparam int FRAME3_LIT = 21;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       ld_valid, ld_ready, ld_enable;
  logic [1:0] ld_index;
  logic [3:0] ld_value;
  logic [3:0] enc_input, enc_output, seg_code;
  logic       enc_ready, frame_done;
  logic [3:0] digit_sel;

  logic       ld_valid3, ld_ready3, ld_enable3;
  logic [1:0] ld_index3;
  logic [3:0] ld_value3;
  logic [3:0] enc_input3, enc_output3, seg_code3;
  logic       enc_ready3, frame_done3;
  logic [2:0] digit_sel3;

`ifdef SCHED_BRIGHTNESS_EN
  logic [2:0] brightness;
  logic [2:0] brightness3;
`endif

  // Shared encoder behaviour: forces 0 when not ready.
  assign enc_output  = enc_ready  ? enc_input  : 4'd0;
  assign enc_output3 = enc_ready3 ? enc_input3 : 4'd0;

  display_scheduler #(.DIGITS(4), .SCAN_DIV(SCAN), .BLANK_CYCLES(BLANK)) dut (
    .Clock(clk), .Reset(rst),
    .Load_Valid(ld_valid), .Load_Ready(ld_ready), .Load_Index(ld_index),
    .Load_Value(ld_value), .Load_Enable(ld_enable),
    .Enc_Input(enc_input), .Enc_Ready(enc_ready), .Enc_Output(enc_output),
    .Seg_Code(seg_code), .Digit_Select(digit_sel), .Frame_Done(frame_done)
`ifdef SCHED_BRIGHTNESS_EN
    , .Brightness(brightness)
`endif
  );

  display_scheduler #(.DIGITS(3), .SCAN_DIV(4), .BLANK_CYCLES(2)) dut3 (
    .Clock(clk), .Reset(rst),
    .Load_Valid(ld_valid3), .Load_Ready(ld_ready3), .Load_Index(ld_index3),
    .Load_Value(ld_value3), .Load_Enable(ld_enable3),
    .Enc_Input(enc_input3), .Enc_Ready(enc_ready3), .Enc_Output(enc_output3),
    .Seg_Code(seg_code3), .Digit_Select(digit_sel3), .Frame_Done(frame_done3)
`ifdef SCHED_BRIGHTNESS_EN
    , .Brightness(brightness3)
`endif
  );

  always #5 clk = ~clk;

  // Model state
  int         t;
  logic [3:0] m_val [DIGITS];
  logic       m_en  [DIGITS];
  logic [3:0] m_seg;
  int         m_on;
  bit         xfer, xfer3, ready3_s, rand_on;
  int         vectors, miscompares;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0d: got %0h expected %0h", name, t, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s t=%0d: bound expired", name, t);
  endtask

  task automatic model_reset();
    t = 0;
    for (int i = 0; i < DIGITS; i++) begin
      m_val[i] = 4'd0;
      m_en[i]  = 1'b0;
    end
    m_seg = 4'd0;
    m_on  = SCAN;
    xfer  = 1'b0;
    xfer3 = 1'b0;
  endtask

  // Advances the model across one rising edge, using pre-edge inputs.
  task automatic model_edge();
    int ph, sl;
    ph   = t % PER;
    sl   = (t / PER) % DIGITS;
    xfer = 1'b0;
    if (ph == BLANK) begin
      m_seg = m_en[sl] ? m_val[sl] : 4'd0;
`ifdef SCHED_BRIGHTNESS_EN
      m_on = ((int'(brightness) + 1) * SCAN) >> 3;
      if (m_on < 1) m_on = 1;
`endif
    end
    if (ld_valid && (t > 0) && (ph != BLANK)) begin
      xfer = 1'b1;
      if (int'(ld_index) < DIGITS) begin
        m_val[ld_index] = ld_value;
        m_en[ld_index]  = ld_enable;
      end
    end
    xfer3 = ld_valid3 && ready3_s;
    t++;
  endtask

  task automatic compare();
    int ph, sl;
    logic [3:0] e_dsel;
    logic [2:0] e_dsel3;
    ph = t % PER;
    sl = (t / PER) % DIGITS;
    chk("load_ready", 32'(ld_ready), 32'((t > 0) && (ph != BLANK)));
    chk("enc_input", 32'(enc_input), (ph == BLANK) ? 32'(m_val[sl]) : 32'd0);
    chk("enc_ready", 32'(enc_ready), (ph == BLANK) ? 32'(m_en[sl]) : 32'd0);
    chk("seg_code", 32'(seg_code), 32'(m_seg));
    e_dsel = 4'd0;
    if ((ph > BLANK) && ((ph - BLANK - 1) < m_on)) e_dsel = 4'(1 << sl);
    chk("digit_select", 32'(digit_sel), 32'(e_dsel));
    chk("frame_done", 32'(frame_done), 32'((t > 0) && (t % FRAME == 0)));
    // DIGITS=3 instance: every write targets index 3, so all slots stay 0.
    ph = t % PER3;
    sl = (t / PER3) % 3;
    chk("ready3", 32'(ld_ready3), 32'((t > 0) && (ph != 2)));
    chk("enc_input3", 32'(enc_input3), 32'd0);
    chk("enc_ready3", 32'(enc_ready3), 32'd0);
    chk("seg3", 32'(seg_code3), 32'd0);
    e_dsel3 = (ph > 2) ? 3'(1 << sl) : 3'd0;
    chk("dsel3", 32'(digit_sel3), 32'(e_dsel3));
    chk("frame3", 32'(frame_done3), 32'((t > 0) && (t % (3 * PER3) == 0)));
  endtask

  task automatic stim();
    if (xfer) ld_valid = 1'b0;
    if (xfer3) begin
      ld_value3  = 4'($urandom);
      ld_enable3 = 1'($urandom);
    end
    if (rand_on && !ld_valid && ($urandom_range(3) == 0)) begin
      ld_valid  = 1'b1;
      ld_index  = 2'($urandom);
      ld_value  = 4'($urandom);
      ld_enable = 1'($urandom);
    end
`ifdef SCHED_BRIGHTNESS_EN
    if (rand_on) brightness = 3'($urandom);
`endif
    ready3_s = ld_ready3;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
    stim();
  endtask

  task automatic do_write(input logic [1:0] idx, input logic [3:0] val, input logic en);
    int n;
    n = 0;
    ld_valid  = 1'b1;
    ld_index  = idx;
    ld_value  = val;
    ld_enable = en;
    while (ld_valid && (n < 50)) begin
      step();
      n++;
    end
    if (ld_valid) begin
      fail_now("write_timeout");
      ld_valid = 1'b0;
    end
  endtask

  task automatic wait_slot_phase(input int sl, input int ph);
    int n;
    n = 0;
    while (!(((t % PER) == ph) && (((t / PER) % DIGITS) == sl)) && (n < 2 * FRAME)) begin
      step();
      n++;
    end
    if (n >= 2 * FRAME) fail_now("wait_slot_phase");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0d: simulation time limit", t);
    $fatal(1, "watchdog");
  end

  initial begin
    int fd_cnt, first_fd, first_fd3, lit0, rdy_cnt, s1, s2, n;
    ld_valid = 1'b0; ld_index = 2'd0; ld_value = 4'd0; ld_enable = 1'b0;
    ld_valid3 = 1'b0; ld_index3 = 2'd3; ld_value3 = 4'hF; ld_enable3 = 1'b1;
`ifdef SCHED_BRIGHTNESS_EN
    brightness = 3'd7; brightness3 = 3'd7;
`endif
    vectors = 0; miscompares = 0; rand_on = 1'b0; ready3_s = 1'b0;
    model_reset();

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_enc_input", 32'(enc_input), 32'd0);
    chk("rst_enc_ready", 32'(enc_ready), 32'd0);
    chk("rst_seg", 32'(seg_code), 32'd0);
    chk("rst_dsel", 32'(digit_sel), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    model_reset();
    ld_valid3 = 1'b1;

    // Free-running scan with no loads
    fd_cnt = 0; first_fd = -1; first_fd3 = -1; lit0 = 0;
    repeat (2 * FRAME) begin
      step();
      if (frame_done) begin
        fd_cnt++;
        if (first_fd < 0) first_fd = t;
      end
      if (frame_done3 && (first_fd3 < 0)) first_fd3 = t;
      if (digit_sel == 4'b0001) lit0++;
    end
    chk("pin_first_frame_done", 32'(first_fd), 32'(FRAME_LIT));
    chk("pin_frame_pulses", 32'(fd_cnt), 32'd2);
    chk("pin_slot0_lit", 32'(lit0), 32'(LIT0_LIT));
    chk("pin_first_frame3", 32'(first_fd3), 32'(FRAME3_LIT));

    // Lit slot 2 = 5, blanked slot 1 = A
    do_write(2'd2, 4'h5, 1'b1);
    do_write(2'd1, 4'hA, 1'b0);
    rdy_cnt = 0; s1 = 0; s2 = 0;
    repeat (FRAME) begin
      step();
      if (enc_ready) rdy_cnt++;
      if ((digit_sel == 4'b0100) && (seg_code == 4'h5)) s2++;
      if ((digit_sel == 4'b0010) && (seg_code == 4'h0)) s1++;
    end
    chk("pin_enc_ready_once", 32'(rdy_cnt), 32'd1);
    chk("pin_slot2_seg5", 32'(s2), 32'(SHOW_LIT));
    chk("pin_slot1_seg0", 32'(s1), 32'(SHOW_LIT));

    // Write requested during DRIVE transfers one cycle later
    wait_slot_phase(0, BLANK);
    chk("pin_ready_low_in_drive", 32'(ld_ready), 32'd0);
    ld_valid = 1'b1; ld_index = 2'd0; ld_value = 4'h3; ld_enable = 1'b1;
    n = 0;
    while (ld_valid && (n < 10)) begin
      step();
      n++;
    end
    chk("pin_xfer_latency", 32'(n), 32'd2);

    // Randomised traffic
    rand_on = 1'b1;
    repeat (1500) step();
    rand_on = 1'b0;
    n = 0;
    while (ld_valid && (n < 20)) begin
      step();
      n++;
    end
    if (ld_valid) fail_now("drain_timeout");
    ld_valid = 1'b0;

    // Asynchronous reset two cycles into slot-2 SHOW
`ifdef SCHED_BRIGHTNESS_EN
    brightness = 3'd7;
`endif
    do_write(2'd2, 4'h9, 1'b1);
    wait_slot_phase(0, 0);
    wait_slot_phase(2, BLANK + 1 + 2);
    chk("pin_pre_rst_dsel", 32'(digit_sel), 32'h4);
    chk("pin_pre_rst_seg", 32'(seg_code), 32'h9);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_dsel", 32'(digit_sel), 32'd0);
    chk("async_rst_seg", 32'(seg_code), 32'd0);
    chk("async_rst_frame_done", 32'(frame_done), 32'd0);
    chk("async_rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("async_rst_enc_ready", 32'(enc_ready), 32'd0);
    chk("async_rst_dsel3", 32'(digit_sel3), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    ready3_s = ld_ready3;
    rst = 1'b0;
    repeat (3) step();
    chk("pin_restart_slot0", 32'(digit_sel), 32'h1);
    repeat (FRAME) step();

`ifdef SCHED_BRIGHTNESS_EN
    // Duty control: Brightness 3 -> 4 of 8 cycles, Brightness 0 -> 1 cycle
    wait_slot_phase(0, 0);
    brightness = 3'd3;
    lit0 = 0; fd_cnt = 0;
    repeat (FRAME) begin
      step();
      if (digit_sel == 4'b0001) lit0++;
      if (frame_done) fd_cnt++;
    end
    chk("pin_bright3_lit", 32'(lit0), 32'd4);
    chk("pin_bright3_frames", 32'(fd_cnt), 32'd1);
    brightness = 3'd0;
    lit0 = 0;
    repeat (FRAME) begin
      step();
      if (digit_sel == 4'b0001) lit0++;
    end
    chk("pin_bright0_lit", 32'(lit0), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
Time-multiplexes one shared 4-bit code encoder and 7-segment decoder path across DIGITS display positions. Holds a per-digit value/enable register file written through a valid/ready load port. For each digit it presents the value to the encoder, captures the encoded result, and drives a one-hot digit select for a fixed dwell time. Sits between the host logic and the Codificador/Display pair.

Parameters:
DIGITS, 4, number of multiplexed digit slots (2..8)
SCAN_DIV, 1000, clock cycles each digit is lit (SHOW dwell, >=2)
BLANK_CYCLES, 2, dead cycles with all digits off before each digit (anti-ghosting, >=1)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
Load_Valid  in  1  host write request
Load_Ready  out  1  scheduler can accept a write this cycle
Load_Index  in  clog2(DIGITS)  target slot
Load_Value  in  4  code value for slot
Load_Enable  in  1  slot lit (1) / blanked (0)
Enc_Input  out  4  value to shared encoder Input
Enc_Ready  out  1  to encoder Ready (encoder Reset tied low)
Enc_Output  in  4  encoder Output, combinational return
Seg_Code  out  4  captured code to Display decoder
Digit_Select  out  DIGITS  one-hot active-high digit enable
Frame_Done  out  1  one-cycle pulse after last slot's SHOW

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. All outputs are registered.
- Reset values:
  - state BLANK, slot pointer 0, counter 0
  - all slot values 0, all enables 0
  - Enc_Input 0, Enc_Ready 0, Seg_Code 0, Digit_Select 0, Frame_Done 0, Load_Ready 0
- Load_Ready rises on the first edge after Reset deasserts.
- Reset asserted mid-operation clears all state immediately (asynchronous), including Digit_Select.
- FSM, per slot:
  - BLANK: Digit_Select=0, Enc_Ready=0, Enc_Input=0. Lasts BLANK_CYCLES cycles, then DRIVE.
  - DRIVE: exactly 1 cycle. Enc_Input=slot value. Enc_Ready=slot enable. Load_Ready=0.
    - On the edge leaving DRIVE, Seg_Code <= Enc_Output.
    - A disabled slot therefore captures 0000, because the encoder forces 0 when Ready=0.
  - SHOW: Digit_Select=one-hot(slot pointer), Enc_Ready=0, Enc_Input=0, Seg_Code held. Lasts SCAN_DIV cycles.
    - Then: pointer increments, wrapping from DIGITS-1 to 0, and state goes to BLANK.
    - Frame_Done is high for the first BLANK cycle after the wrap only.
- Per-slot period: BLANK_CYCLES+1+SCAN_DIV cycles. Frame period: DIGITS times the per-slot period.
- Load handshake:
  - A write transfers on an edge where Load_Valid & Load_Ready.
  - Load_Ready=1 in every state except DRIVE and reset.
  - Host holds Load_Valid and Load_Value stable until transfer.
  - Load_Index >= DIGITS: transfer completes (handshake accepted), write dropped.
  - A write to the slot currently in SHOW does not change Seg_Code; it takes effect on that slot's next DRIVE.
  - Load-to-visible latency is at most one frame period.
- Counter width: clog2(max(SCAN_DIV, BLANK_CYCLES)+1). Counter resets to 0 on every state entry.

Optional Feature:
SCHED_BRIGHTNESS_EN
- Defined:
  - Adds input Brightness [2:0], sampled at SHOW entry.
  - Digit_Select is asserted only for the first on_cycles of SHOW, where on_cycles = max(1, ((Brightness+1)*SCAN_DIV)>>3). Digit_Select is 0 for the rest of SHOW.
  - SHOW duration is unchanged, so frame timing is identical.
- Undefined: no Brightness port; Digit_Select is asserted for all SCAN_DIV cycles.

Test Plan:
All scenarios use DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=2; the bench models Enc_Output = Enc_Ready ? Enc_Input : 0.
1. Release Reset, no loads -> Digit_Select walks 0001,0010,0100,1000 (4 cycles lit, 3 off per slot). Seg_Code=0 throughout. Frame_Done pulses once every 28 cycles.
2. Write index 2, value 4'h5, enable 1 -> on the next slot-2 visit, Enc_Ready=1 for exactly 1 cycle with Enc_Input=5. Seg_Code=5 while Digit_Select=0100.
3. Write index 1, value 4'hA, enable 0 -> slot-1 DRIVE has Enc_Ready=0. Seg_Code=0 while Digit_Select=0010.
4. Assert Load_Valid during a DRIVE cycle -> Load_Ready=0 that cycle; transfer completes on the next cycle. Then write index 3 with DIGITS=3 build -> accepted, no slot changes.
5. Assert Reset 2 cycles into slot-2 SHOW -> Digit_Select, Seg_Code, Frame_Done go to 0 without a clock edge. After release, scanning restarts at slot 0 with all enables 0.
6. With SCHED_BRIGHTNESS_EN, SCAN_DIV=8, Brightness=3 -> Digit_Select high for 4 of 8 SHOW cycles. Brightness=0 -> 1 cycle. Frame period unchanged at 44 cycles.
